// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a clear sequencer and busy/ready handshake.
// Define REGFILE_WR_BYPASS_EN to forward a committing write to matching read ports in the same cycle.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_TOP = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] TOP = '1;
  typedef enum logic [1:0] {IDLE = 2'b01, CLEAR = 2'b10} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_commit;
  assign clr_busy = state == CLEAR;
  assign wr_ready = !clr_busy;
  assign wr_commit = wr_en && wr_ready && !(ZERO_TOP != 0 && wr_addr == TOP);
  // Any encoding other than CLEAR behaves as IDLE, so illegal states fall back there.
  always_comb begin
    state_nx = clr_busy ? (cnt == TOP ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
    cnt_nx = clr_busy ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (clr_busy) mem[cnt] <= '0;
    else if (wr_commit) mem[wr_addr] <= wr_data;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] stored;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign stored = (ZERO_TOP != 0 && a == TOP) ? '0 : mem[a];
`ifdef REGFILE_WR_BYPASS_EN
    assign rd_data[k*DATA_W +: DATA_W] = (wr_commit && a == wr_addr) ? wr_data : stored;
`else
    assign rd_data[k*DATA_W +: DATA_W] = stored;
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench running a ZERO_TOP=1 and a ZERO_TOP=0 instance side by side
// against an array-based reference model of the register file.
module tb_regfile_mp;
  localparam int DW = 64, AW = 5, NR = 3, DEPTH = 32;
  logic clk = 0, reset_n = 0, wr_en = 0, clr_req = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data0, rd_data1;
  logic wr_ready0, wr_ready1, clr_busy0, clr_busy1;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    int id;
    logic [NR*DW-1:0] rd0, rd1;
    logic rdy, bsy;
  } exp_t;
  exp_t q[$];

  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] m1 [DEPTH];
  int clr_left = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_TOP(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready0), .rd_addr(rd_addr), .rd_data(rd_data0), .clr_req(clr_req),
    .clr_busy(clr_busy0));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_TOP(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready1), .rd_addr(rd_addr), .rd_data(rd_data1), .clr_req(clr_req),
    .clr_busy(clr_busy1));

  function automatic logic [NR*AW-1:0] ra3(input int a, input int b, input int c);
    return {AW'(c), AW'(b), AW'(a)};
  endfunction

  task automatic chk(input string name, input int id, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, id, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, predict outputs, then advance the model at posedge.
  task automatic step(input logic we, input int wa, input logic [DW-1:0] wd,
                      input logic [NR*AW-1:0] ra, input logic cr, input logic rn);
    exp_t e;
    logic c0, c1;
    @(negedge clk);
    wr_en = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    rd_addr = ra;
    clr_req = cr;
    reset_n = rn;
    if (!rn) begin
      for (int i = 0; i < DEPTH; i++) begin
        m0[i] = '0;
        m1[i] = '0;
      end
      clr_left = 0;
    end
    c0 = rn && we && clr_left == 0 && wa != DEPTH - 1;
    c1 = rn && we && clr_left == 0;
    e.id = cyc++;
    e.rdy = clr_left == 0;
    e.bsy = clr_left != 0;
    for (int p = 0; p < NR; p++) begin
      int a;
      logic [DW-1:0] v0, v1;
      a = int'(ra[p*AW +: AW]);
      v0 = (a == DEPTH - 1) ? '0 : m0[a];
      v1 = m1[a];
`ifdef REGFILE_WR_BYPASS_EN
      if (c0 && a == wa) v0 = wd;
      if (c1 && a == wa) v1 = wd;
`endif
      e.rd0[p*DW +: DW] = v0;
      e.rd1[p*DW +: DW] = v1;
    end
    q.push_back(e);
    @(posedge clk);
    if (rn) begin
      if (clr_left > 0) begin
        m0[DEPTH - clr_left] = '0;
        m1[DEPTH - clr_left] = '0;
        clr_left--;
      end else begin
        if (c0) m0[wa] = wd;
        if (c1) m1[wa] = wd;
        if (cr) clr_left = DEPTH;
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < NR; p++) begin
          chk("rd_data_zt1", e.id, rd_data0[p*DW +: DW], e.rd0[p*DW +: DW]);
          chk("rd_data_zt0", e.id, rd_data1[p*DW +: DW], e.rd1[p*DW +: DW]);
        end
        chk("wr_ready_zt1", e.id, DW'(wr_ready0), DW'(e.rdy));
        chk("wr_ready_zt0", e.id, DW'(wr_ready1), DW'(e.rdy));
        chk("clr_busy_zt1", e.id, DW'(clr_busy0), DW'(e.bsy));
        chk("clr_busy_zt0", e.id, DW'(clr_busy1), DW'(e.bsy));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    step(0, 0, '0, ra3(0, 1, 31), 0, 0);
    step(0, 0, '0, ra3(0, 1, 31), 0, 1);
    // Reset in the middle of normal operation wipes written data at once.
    step(1, 3, 64'hDEAD_BEEF, ra3(3, 3, 3), 0, 1);
    step(0, 0, '0, ra3(3, 0, 3), 0, 1);
    step(0, 0, '0, ra3(3, 3, 3), 0, 0);
    step(0, 0, '0, ra3(3, 3, 3), 0, 1);
    // Multi-port reads of the same and different addresses.
    step(1, 5, 64'h1234, ra3(5, 30, 5), 0, 1);
    step(1, 30, '1, ra3(5, 30, 5), 0, 1);
    step(0, 0, '0, ra3(5, 30, 5), 0, 1);
    // Top register: hardwired zero on one instance, ordinary on the other.
    step(1, 31, 64'hABCD, ra3(31, 5, 31), 0, 1);
    step(0, 0, '0, ra3(31, 30, 5), 0, 1);
    // Fill with index, then clear; writes and a second clr_req during busy are ignored.
    for (int i = 0; i < DEPTH; i++) step(1, i, DW'(i), ra3(i, 9, 10), 0, 1);
    step(0, 0, '0, ra3(9, 10, 2), 1, 1);
    for (int i = 0; i < DEPTH; i++) step(i == 4, 2, 64'h22, ra3(9, 10, 2), i == 6, 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, ra3(2, 31, 10), 0, 1);
    // Write and clr_req together, then reset partway through the clear.
    for (int i = 0; i < DEPTH; i++) step(1, i, DW'(i) + 64'h100, ra3(i, 0, 0), 0, 1);
    step(1, 7, 64'h77, ra3(7, 7, 7), 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, '0, ra3(7, 20, 31), 0, i != 15);
    step(0, 0, '0, ra3(7, 20, 31), 0, 1);
    // Same-cycle write/read of one address, including the top register.
    step(1, 4, 64'h99, ra3(4, 4, 0), 0, 1);
    step(1, 4, 64'h44, ra3(4, 31, 4), 0, 1);
    step(1, 31, 64'h55, ra3(4, 31, 31), 0, 1);
    step(0, 0, '0, ra3(4, 31, 4), 0, 1);
    for (int i = 0; i < 600; i++) begin
      logic rn, we;
      rn = $urandom_range(0, 199) != 0;
      we = rn && ($urandom_range(0, 3) != 0);
      step(we, $urandom_range(0, DEPTH - 1), {$urandom, $urandom},
           ra3($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1)),
           $urandom_range(0, 39) == 0, rn);
    end
    step(0, 0, '0, ra3(0, 1, 2), 0, 1);
    @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
